// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one DMA/RAM port between the file loader (0),
// the decompressor (1) and the CNN engine (2). One RAM transaction per grant;
// the winner's command is latched so requesters may change their inputs freely
// once granted. A cycle counter aborts transactions the DMA never acknowledges.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a visible request; latches winner and command
//   S_ISSUE | one-cycle ram_read/ram_write strobe, timeout counter cleared
//   S_WAIT  | waiting for the matching DMA completion or timeout
//   S_DONE  | done pulse (with rdata/err) to the winner; gnt drops after
module ram_access_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [2:0]            req_en,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_read,
  output logic                  ram_write,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_done_read,
  input  logic                  ram_done_write
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Counter value in the last permitted WAIT cycle (TIMEOUT cycles in WAIT).
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_last;
  logic                r_we;
  logic [7:0]          r_cnt;
  logic [2:0]          r_gnt;
  logic [2:0]          r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_ram_read;
  logic                r_ram_write;

  logic [2:0]          w_vis;
  logic                w_any;
  logic [1:0]          w_win;
  logic                w_match;
  logic                w_tc;
  logic                w_latch;
  logic                w_finish;
  logic [ADDR_W-1:0]   w_addr_arr  [3];
  logic [DATA_W-1:0]   w_wdata_arr [3];

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_read  = r_ram_read;
  assign ram_write = r_ram_write;

  // Unpack the per-requester command buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: search last+1, last+2, then last itself.
  always_comb begin
    w_vis = req & req_en;
    w_any = |w_vis;
    w_win = 2'd0;
    case (r_last)
      2'd0: begin
        if (w_vis[1])      w_win = 2'd1;
        else if (w_vis[2]) w_win = 2'd2;
        else               w_win = 2'd0;
      end
      2'd1: begin
        if (w_vis[2])      w_win = 2'd2;
        else if (w_vis[0]) w_win = 2'd0;
        else               w_win = 2'd1;
      end
      default: begin
        if (w_vis[0])      w_win = 2'd0;
        else if (w_vis[1]) w_win = 2'd1;
        else               w_win = 2'd2;
      end
    endcase
  end

  // Next-state logic; only the completion matching the latched command counts.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_finish    = 1'b0;
    w_match     = r_we ? ram_done_write : ram_done_read;
    w_tc        = (r_cnt == TC_LAST);
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_match || w_tc) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Command latch, strobes, counter and completion outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_last      <= 2'd2;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
    end else begin
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      if (w_latch) begin
        r_last      <= w_win;
        r_we        <= req_we[w_win];
        r_ram_addr  <= w_addr_arr[w_win];
        r_ram_wdata <= w_wdata_arr[w_win];
        r_gnt       <= 3'b001 << w_win;
        r_ram_read  <= ~req_we[w_win];
        r_ram_write <= req_we[w_win];
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      if (r_state == S_WAIT)  r_cnt <= r_cnt + 8'd1;
      if (w_finish) begin
        r_done <= 3'b001 << r_last;
        r_err  <= ~w_match;
        if (w_match && !r_we) r_rdata <= ram_rdata;
      end
      if (r_state == S_DONE) r_gnt <= '0;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: single read, round-robin writes,
// enable masking, DMA timeout, completion-type filtering and mid-transaction reset.
module tb_ram_access_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            RST;
  logic [2:0]      req_en, req, req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      gnt, done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_read, ram_write;
  logic [DW-1:0]   ram_rdata;
  logic            ram_done_read, ram_done_write;

  int n_cmp = 0;
  int n_bad = 0;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk(clk), .RST(RST), .req_en(req_en), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_rdata(ram_rdata),
    .ram_done_read(ram_done_read), .ram_done_write(ram_done_write)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req = '0; req_we = '0; req_en = 3'b111; req_addr = '0; req_wdata = '0;
    ram_rdata = '0; ram_done_read = 1'b0; ram_done_write = 1'b0;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick;
    tick;
    RST = 1'b0;
  endtask

  // Cycles until a RAM strobe is visible; -1 if none within budget.
  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 0; i < 20 && n < 0; i++) begin
      if (ram_read || ram_write) n = i;
      else tick;
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    do_reset;
    n_cmp++;
    if ({gnt, done, err, ram_read, ram_write} !== 9'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, ram_read, ram_write});
    end
    n_cmp++;
    if ({rdata, ram_addr, ram_wdata} !== 32'd0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {rdata, ram_addr, ram_wdata});
    end
  endtask

  task automatic test_single_read;
    int n;
    req = 3'b001; req_we = 3'b000; req_addr[0 +: AW] = 16'h1234;
    wait_strobe(n);
    n_cmp++;
    if (n !== 1) begin n_bad++; $display("FAIL rd_latency: got %0d want 1", n); end
    n_cmp++;
    if ({ram_read, ram_write, gnt} !== 5'b10_001) begin
      n_bad++; $display("FAIL rd_strobe: got %b want 10001", {ram_read, ram_write, gnt});
    end
    n_cmp++;
    if (ram_addr !== 16'h1234) begin n_bad++; $display("FAIL rd_addr: got %h want 1234", ram_addr); end
    req_addr[0 +: AW] = 16'hFFFF;
    tick;
    n_cmp++;
    if (ram_read !== 1'b0) begin n_bad++; $display("FAIL rd_one_pulse: got %b want 0", ram_read); end
    tick;
    tick;
    ram_done_read = 1'b1; ram_rdata = 8'hA5;
    tick;
    ram_done_read = 1'b0; ram_rdata = 8'h00;
    n_cmp++;
    if ({done, err, rdata} !== {3'b001, 1'b0, 8'hA5}) begin
      n_bad++; $display("FAIL rd_done: got %b/%b/%h want 001/0/a5", done, err, rdata);
    end
    n_cmp++;
    if ({gnt, ram_addr} !== {3'b001, 16'h1234}) begin
      n_bad++; $display("FAIL rd_hold: got %b/%h want 001/1234", gnt, ram_addr);
    end
    req = 3'b000;
    tick;
    n_cmp++;
    if ({done, gnt} !== 6'd0) begin n_bad++; $display("FAIL rd_release: got %b want 0", {done, gnt}); end
  endtask

  task automatic test_round_robin;
    int n;
    logic [2:0]    exp_gnt   [4];
    logic [AW-1:0] exp_addr  [3];
    logic [DW-1:0] exp_wdata [3];
    int            exp_idx   [4];
    exp_gnt   = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_idx   = '{0, 1, 2, 0};
    exp_addr  = '{16'h0A00, 16'h0B01, 16'h0C02};
    exp_wdata = '{8'h10, 8'h21, 8'h32};
    idle_inputs;
    do_reset;
    req_we = 3'b111;
    req_addr  = {16'h0C02, 16'h0B01, 16'h0A00};
    req_wdata = {8'h32, 8'h21, 8'h10};
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n);
      n_cmp++;
      if (n !== ((k == 0) ? 1 : 2)) begin
        n_bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k, n, (k == 0) ? 1 : 2);
      end
      n_cmp++;
      if ({gnt, ram_write, ram_read} !== {exp_gnt[k], 2'b10}) begin
        n_bad++; $display("FAIL rr_gnt%0d: got %b want %b10", k, {gnt, ram_write, ram_read}, exp_gnt[k]);
      end
      n_cmp++;
      if ({ram_addr, ram_wdata} !== {exp_addr[exp_idx[k]], exp_wdata[exp_idx[k]]}) begin
        n_bad++; $display("FAIL rr_cmd%0d: got %h/%h want %h/%h", k, ram_addr, ram_wdata,
                          exp_addr[exp_idx[k]], exp_wdata[exp_idx[k]]);
      end
      tick;
      ram_done_write = 1'b1;
      tick;
      ram_done_write = 1'b0;
      n_cmp++;
      if (done !== exp_gnt[k]) begin n_bad++; $display("FAIL rr_done%0d: got %b want %b", k, done, exp_gnt[k]); end
    end
    req = 3'b000;
    tick;
  endtask

  task automatic test_mask;
    int n;
    idle_inputs;
    do_reset;
    req = 3'b110; req_en = 3'b011;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(n);
      n_cmp++;
      if ({n >= 0, gnt} !== 4'b1_010) begin
        n_bad++; $display("FAIL mask_gnt%0d: got %b (wait %0d) want 010", k, gnt, n);
      end
      tick;
      ram_done_read = 1'b1; ram_rdata = 8'(8'h40 + k);
      tick;
      ram_done_read = 1'b0;
      n_cmp++;
      if ({done, rdata} !== {3'b010, 8'(8'h40 + k)}) begin
        n_bad++; $display("FAIL mask_done%0d: got %b/%h want 010/%h", k, done, rdata, 8'(8'h40 + k));
      end
    end
    req_en = 3'b111;
    wait_strobe(n);
    n_cmp++;
    if ({n >= 0, gnt} !== 4'b1_100) begin
      n_bad++; $display("FAIL mask_unfence: got %b (wait %0d) want 100", gnt, n);
    end
    tick;
    ram_done_read = 1'b1;
    tick;
    ram_done_read = 1'b0;
    n_cmp++;
    if (done !== 3'b100) begin n_bad++; $display("FAIL mask_done2: got %b want 100", done); end
    req = 3'b000;
    tick;
  endtask

  task automatic test_timeout;
    int n;
    idle_inputs;
    do_reset;
    req = 3'b001; req_we = 3'b001; ram_rdata = 8'h77;
    wait_strobe(n);
    n_cmp++;
    if ({n >= 0, ram_write} !== 2'b11) begin
      n_bad++; $display("FAIL to_strobe: got write=%b (wait %0d) want 1", ram_write, n);
    end
    n = 0;
    for (int i = 0; i < 300 && done === 3'b000; i++) begin
      tick;
      n++;
    end
    n_cmp++;
    if (n !== 256) begin n_bad++; $display("FAIL to_cycles: got %0d want 256", n); end
    n_cmp++;
    if ({done, err, rdata} !== {3'b001, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL to_done: got %b/%b/%h want 001/1/00", done, err, rdata);
    end
    req = 3'b010; req_we = 3'b000; ram_rdata = 8'h5A;
    wait_strobe(n);
    n_cmp++;
    if ({n >= 0, gnt, ram_read} !== 5'b1_010_1) begin
      n_bad++; $display("FAIL to_next: got %b/%b (wait %0d) want 010/1", gnt, ram_read, n);
    end
    tick;
    ram_done_read = 1'b1;
    tick;
    ram_done_read = 1'b0;
    n_cmp++;
    if ({done, err, rdata} !== {3'b010, 1'b0, 8'h5A}) begin
      n_bad++; $display("FAIL to_next_done: got %b/%b/%h want 010/0/5a", done, err, rdata);
    end
    req = 3'b000;
    tick;
  endtask

  task automatic test_done_filter;
    int n;
    idle_inputs;
    do_reset;
    req = 3'b001; req_we = 3'b000; req_addr[0 +: AW] = 16'h0042;
    wait_strobe(n);
    tick;
    ram_done_write = 1'b1;
    tick;
    ram_done_write = 1'b0;
    n_cmp++;
    if (done !== 3'b000) begin n_bad++; $display("FAIL flt_wr_ignored: got %b want 000", done); end
    tick;
    ram_done_read = 1'b1; ram_rdata = 8'h3C;
    n_cmp++;
    if (done !== 3'b000) begin n_bad++; $display("FAIL flt_still_wait: got %b want 000", done); end
    tick;
    ram_done_read = 1'b0;
    n_cmp++;
    if ({done, err, rdata} !== {3'b001, 1'b0, 8'h3C}) begin
      n_bad++; $display("FAIL flt_rd_done: got %b/%b/%h want 001/0/3c", done, err, rdata);
    end
    req = 3'b000;
    tick;
    req = 3'b001; req_we = 3'b001;
    wait_strobe(n);
    tick;
    ram_done_read = 1'b1; ram_rdata = 8'h99;
    tick;
    n_cmp++;
    if (done !== 3'b000) begin n_bad++; $display("FAIL flt_rd_ignored: got %b want 000", done); end
    ram_done_write = 1'b1;
    tick;
    ram_done_read = 1'b0; ram_done_write = 1'b0;
    n_cmp++;
    if ({done, err, rdata} !== {3'b001, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL flt_both: got %b/%b/%h want 001/0/00", done, err, rdata);
    end
    req = 3'b000;
    tick;
  endtask

  task automatic test_mid_reset;
    int n;
    idle_inputs;
    do_reset;
    req = 3'b010; req_addr[AW +: AW] = 16'h0777; req_wdata[DW +: DW] = 8'h5E;
    wait_strobe(n);
    tick;
    RST = 1'b1; ram_done_read = 1'b1; ram_rdata = 8'hEE;
    tick;
    n_cmp++;
    if ({gnt, done, err, ram_read, ram_write} !== 9'd0) begin
      n_bad++; $display("FAIL mr_ctrl: got %b want 0", {gnt, done, err, ram_read, ram_write});
    end
    n_cmp++;
    if ({rdata, ram_addr, ram_wdata} !== 32'd0) begin
      n_bad++; $display("FAIL mr_data: got %h want 0", {rdata, ram_addr, ram_wdata});
    end
    RST = 1'b0; req = 3'b011;
    tick;
    ram_done_read = 1'b0;
    n_cmp++;
    if ({gnt, ram_read, done} !== 7'b001_1_000) begin
      n_bad++; $display("FAIL mr_first: got %b/%b/%b want 001/1/000", gnt, ram_read, done);
    end
    tick;
    ram_done_read = 1'b1; ram_rdata = 8'h11;
    tick;
    ram_done_read = 1'b0;
    n_cmp++;
    if ({done, rdata} !== {3'b001, 8'h11}) begin
      n_bad++; $display("FAIL mr_done: got %b/%h want 001/11", done, rdata);
    end
    req = 3'b000;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    idle_inputs;
    test_reset;
    test_single_read;
    test_round_robin;
    test_mask;
    test_timeout;
    test_done_filter;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
